alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter RING_LIMIT_S, default 300, sets the seconds of continuous ringing before auto-stop.
REQ-002 Parameter SNOOZE_S, default 540, sets the snooze duration in seconds.
REQ-003 Parameter SNOOZE_MAX, default 3, sets the snoozes allowed per alarm event.
REQ-004 Parameter VOL_STEP, default 8'h20, sets the per-second volume ramp increment.
REQ-005 Parameter VOL_MAX, default 8'hE0, sets the volume ceiling.
REQ-006 CLK, input, 1 bit: the single clock; 50 MHz system clock; all state changes on posedge CLK.
REQ-007 reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 tick_1hz, input, 1 bit: one-CLK-wide pulse once per second, synchronous to CLK.
REQ-009 time_now, input, 24 bits: current time, packed BCD HH:MM:SS.
REQ-010 alarm_time, input, 24 bits: alarm setpoint, packed BCD HH:MM:SS.
REQ-011 arm, input, 1 bit: level; 1 = alarm enabled.
REQ-012 snooze, input, 1 bit: one-CLK pulse, debounced upstream.
REQ-013 dismiss, input, 1 bit: one-CLK pulse, debounced upstream.
REQ-014 vol, output, 8 bits: audio volume to the audio generator.
REQ-015 ringing, output, 1 bit: high in RINGING.
REQ-016 snoozing, output, 1 bit: high in SNOOZING.
REQ-017 alarm_indicator, output, 1 bit: high in ARMED, RINGING or SNOOZING.
REQ-018 snooze_left, output, 2 bits: remaining snoozes.

Function
REQ-019 FSM states: IDLE, ARMED, RINGING, SNOOZING; all outputs registered.
REQ-020 IDLE -> ARMED when arm=1; any state -> IDLE on the cycle after arm=0 is sampled, with vol=0.
REQ-021 match = (time_now == alarm_time); the trigger fires only on the rising edge of match (registered previous value), so one event per matching second.
REQ-022 ARMED -> RINGING on trigger; snooze_left loads SNOOZE_MAX, vol loads VOL_STEP, ring counter clears — all in the same transition cycle.
REQ-023 RINGING: each tick_1hz adds VOL_STEP to vol, saturating at VOL_MAX (no 8-bit wrap), and increments the ring counter.
REQ-024 RINGING -> ARMED with vol=0 when the ring counter reaches RING_LIMIT_S ticks.
REQ-025 RINGING -> ARMED with vol=0 on dismiss.
REQ-026 RINGING + snooze with snooze_left>0 -> SNOOZING; vol=0, snooze_left decrements, snooze counter loads SNOOZE_S.
REQ-027 RINGING + snooze with snooze_left=0: the snooze is ignored and ringing continues.
REQ-028 SNOOZING: each tick decrements the snooze counter; at 0 -> RINGING, vol=VOL_STEP, ring counter clears.
REQ-029 SNOOZING + dismiss -> ARMED; snooze input is ignored.
REQ-030 Same-cycle priority: arm=0 > dismiss > snooze > ring timeout/snooze expiry > trigger.
REQ-031 A trigger arriving while in RINGING or SNOOZING is ignored; there is no re-trigger.
REQ-032 Transitions take effect on the CLK edge after the input is sampled (1-cycle latency).
REQ-033 Counters are wide enough for the parameters (ring 9 bits and snooze 10 bits at defaults); no overflow.

Reset
REQ-034 On reset=0, asynchronously: state=IDLE; vol=0; ringing, snoozing and alarm_indicator=0; snooze_left=0; counters=0; match history=0.
REQ-035 Reset asserted mid-ring silences vol immediately, without waiting for CLK.
REQ-036 After release, the first trigger requires a fresh rising edge of match.

Structure
REQ-037 Package alarm_pkg holds the state encoding, the VOL_* constants and the default time-limit constants.
REQ-038 One sub-module, sec_downcounter (loadable, tick-enabled, zero flag), is used for both the ring and snooze timers.

Verification (test parameters RING_LIMIT_S=5, SNOOZE_S=3, SNOOZE_MAX=2)
REQ-039 Trigger and ramp: arm=1, alarm_time=24'h070000, time_now steps 24'h065959 -> 24'h070000 -> ringing=1, vol=8'h20, then 8'h40 and 8'h60 on successive ticks.
REQ-040 Timeout: no input for 5 ticks after trigger -> ARMED, vol=0; time_now held at 24'h070000 causes no retrigger.
REQ-041 Snooze: snooze while ringing -> snoozing=1, snooze_left=1; 3 ticks -> ringing=1, vol=8'h20; second snooze -> snooze_left=0; third snooze ignored.
REQ-042 Conflicts: dismiss and snooze in the same cycle -> ARMED, snooze_left unchanged; arm=0 together with dismiss -> IDLE.
REQ-043 Saturation: VOL_STEP=8'h50, 4 ticks -> vol sequence 50, A0, E0, E0.
REQ-044 Async reset: assert reset between CLK edges while ringing -> vol=0 and state IDLE before the next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, volume
// constants, default time limits and a counter-width helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZING = 2'd3
  } alarm_state_t;

  localparam logic [7:0] VOL_OFF      = 8'h00;
  localparam logic [7:0] VOL_STEP_DEF = 8'h20;
  localparam logic [7:0] VOL_MAX_DEF  = 8'hE0;

  localparam int unsigned RING_LIMIT_S_DEF = 300;
  localparam int unsigned SNOOZE_S_DEF     = 540;
  localparam int unsigned SNOOZE_MAX_DEF   = 3;

  // Bits needed to hold the value n (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n < 2) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sec_downcounter.sv
// Loadable seconds down-counter, decremented by the 1 Hz tick. Shared by the
// ring-duration and snooze-duration timers.
module sec_downcounter #(
  parameter int unsigned W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_zero,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero   = (r_count == '0);
  // Asserted on the tick that takes the count from one to zero, so the owner
  // can act on the same edge the final second elapses.
  assign o_expire = i_tick && (r_count == W'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms on level, rings on the rising edge of a time match,
// ramps volume once per second, and supports limited snoozes and dismiss.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned RING_LIMIT_S = RING_LIMIT_S_DEF,
  parameter int unsigned SNOOZE_S     = SNOOZE_S_DEF,
  parameter int unsigned SNOOZE_MAX   = SNOOZE_MAX_DEF,
  parameter logic [7:0]  VOL_STEP     = VOL_STEP_DEF,
  parameter logic [7:0]  VOL_MAX      = VOL_MAX_DEF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic [23:0] time_now,
  input  logic [23:0] alarm_time,
  input  logic        arm,
  input  logic        snooze,
  input  logic        dismiss,
  output logic [7:0]  vol,
  output logic        ringing,
  output logic        snoozing,
  output logic        alarm_indicator,
  output logic [1:0]  snooze_left
);

  localparam int unsigned RING_W = cnt_width(RING_LIMIT_S);
  localparam int unsigned SNZ_W  = cnt_width(SNOOZE_S);

  alarm_state_t r_state;
  alarm_state_t w_state_nx;

  logic [7:0] r_vol;
  logic [7:0] w_vol_nx;
  logic [1:0] r_snooze_left;
  logic [1:0] w_left_nx;
  logic       r_ringing;
  logic       r_snoozing;
  logic       r_alarm_ind;
  logic       r_match_prev;

  logic       w_match;
  logic       w_trigger;
  logic [8:0] w_vol_sum;
  logic [7:0] w_vol_ramp;

  logic w_ring_load;
  logic w_ring_tick;
  logic w_ring_zero;
  logic w_ring_expire;
  logic w_snz_load;
  logic w_snz_tick;
  logic w_snz_zero;
  logic w_snz_expire;

  assign w_match   = (time_now == alarm_time);
  assign w_trigger = w_match && !r_match_prev;

  // Sum is one bit wider so the ceiling compare never sees an 8-bit wrap.
  assign w_vol_sum  = {1'b0, r_vol} + {1'b0, VOL_STEP};
  assign w_vol_ramp = (w_vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : w_vol_sum[7:0];

  assign w_ring_tick = tick_1hz && (r_state == ST_RINGING);
  assign w_snz_tick  = tick_1hz && (r_state == ST_SNOOZING);

  sec_downcounter #(
    .W (RING_W)
  ) u_ring_cnt (
    .i_clk      (CLK),
    .i_rst_n    (reset),
    .i_load     (w_ring_load),
    .i_load_val (RING_W'(RING_LIMIT_S)),
    .i_tick     (w_ring_tick),
    .o_zero     (w_ring_zero),
    .o_expire   (w_ring_expire)
  );

  sec_downcounter #(
    .W (SNZ_W)
  ) u_snz_cnt (
    .i_clk      (CLK),
    .i_rst_n    (reset),
    .i_load     (w_snz_load),
    .i_load_val (SNZ_W'(SNOOZE_S)),
    .i_tick     (w_snz_tick),
    .o_zero     (w_snz_zero),
    .o_expire   (w_snz_expire)
  );

  // Branch order inside each state encodes the same-cycle priority:
  // arm drop, then dismiss, then snooze, then timer expiry, then trigger.
  always_comb begin
    w_state_nx  = r_state;
    w_vol_nx    = r_vol;
    w_left_nx   = r_snooze_left;
    w_ring_load = 1'b0;
    w_snz_load  = 1'b0;

    if (!arm) begin
      w_state_nx = ST_IDLE;
      w_vol_nx   = VOL_OFF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_trigger) begin
            w_state_nx  = ST_RINGING;
            w_left_nx   = 2'(SNOOZE_MAX);
            w_vol_nx    = VOL_STEP;
            w_ring_load = 1'b1;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            w_state_nx = ST_ARMED;
            w_vol_nx   = VOL_OFF;
          end else if (snooze && (r_snooze_left != 2'd0)) begin
            w_state_nx = ST_SNOOZING;
            w_vol_nx   = VOL_OFF;
            w_left_nx  = r_snooze_left - 2'd1;
            w_snz_load = 1'b1;
          end else if (w_ring_expire || w_ring_zero) begin
            w_state_nx = ST_ARMED;
            w_vol_nx   = VOL_OFF;
          end else if (tick_1hz) begin
            w_vol_nx = w_vol_ramp;
          end
        end
        ST_SNOOZING: begin
          if (dismiss) begin
            w_state_nx = ST_ARMED;
            w_vol_nx   = VOL_OFF;
          end else if (w_snz_expire || w_snz_zero) begin
            w_state_nx  = ST_RINGING;
            w_vol_nx    = VOL_STEP;
            w_ring_load = 1'b1;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_vol_nx   = VOL_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_vol         <= VOL_OFF;
      r_snooze_left <= '0;
      r_ringing     <= 1'b0;
      r_snoozing    <= 1'b0;
      r_alarm_ind   <= 1'b0;
      r_match_prev  <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_vol         <= w_vol_nx;
      r_snooze_left <= w_left_nx;
      r_ringing     <= (w_state_nx == ST_RINGING);
      r_snoozing    <= (w_state_nx == ST_SNOOZING);
      r_alarm_ind   <= (w_state_nx != ST_IDLE);
      r_match_prev  <= w_match;
    end
  end

  assign vol             = r_vol;
  assign ringing         = r_ringing;
  assign snoozing        = r_snoozing;
  assign alarm_indicator = r_alarm_ind;
  assign snooze_left     = r_snooze_left;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: two instances (ramp step 0x20 and 0x50) driven
// in lockstep and compared every cycle against a behavioural model.
module tb_alarm_sequencer;

  localparam int RING = 5;
  localparam int SNZ  = 3;
  localparam int SMAX = 2;
  localparam int MAXV = 'hE0;
  localparam logic [23:0] T_ALARM = 24'h070000;
  localparam logic [23:0] T_PRE   = 24'h065959;
  localparam logic [23:0] T_POST  = 24'h070001;

  logic        CLK = 1'b0;
  logic        reset;
  logic        tick;
  logic [23:0] tn;
  logic [23:0] at;
  logic        arm;
  logic        snz;
  logic        dis;

  logic [7:0] vol      [2];
  logic       ringing  [2];
  logic       snoozing [2];
  logic       ind      [2];
  logic [1:0] sl       [2];

  int n_chk = 0;
  int n_err = 0;

  bit m_act  [2];
  bit m_ring [2];
  bit m_snz  [2];
  bit m_prev [2];
  int m_vol  [2];
  int m_left [2];
  int m_rsec [2];
  int m_ssec [2];

  always #10 CLK = ~CLK;

  alarm_sequencer #(
    .RING_LIMIT_S (RING),
    .SNOOZE_S     (SNZ),
    .SNOOZE_MAX   (SMAX),
    .VOL_STEP     (8'h20),
    .VOL_MAX      (8'hE0)
  ) u_dut_a (
    .CLK             (CLK),
    .reset           (reset),
    .tick_1hz        (tick),
    .time_now        (tn),
    .alarm_time      (at),
    .arm             (arm),
    .snooze          (snz),
    .dismiss         (dis),
    .vol             (vol[0]),
    .ringing         (ringing[0]),
    .snoozing        (snoozing[0]),
    .alarm_indicator (ind[0]),
    .snooze_left     (sl[0])
  );

  alarm_sequencer #(
    .RING_LIMIT_S (RING),
    .SNOOZE_S     (SNZ),
    .SNOOZE_MAX   (SMAX),
    .VOL_STEP     (8'h50),
    .VOL_MAX      (8'hE0)
  ) u_dut_b (
    .CLK             (CLK),
    .reset           (reset),
    .tick_1hz        (tick),
    .time_now        (tn),
    .alarm_time      (at),
    .arm             (arm),
    .snooze          (snz),
    .dismiss         (dis),
    .vol             (vol[1]),
    .ringing         (ringing[1]),
    .snoozing        (snoozing[1]),
    .alarm_indicator (ind[1]),
    .snooze_left     (sl[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int step_of(input int k);
    return (k == 0) ? 'h20 : 'h50;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_ring[k] = 0; m_snz[k] = 0; m_prev[k] = 0;
      m_vol[k] = 0; m_left[k] = 0; m_rsec[k] = 0; m_ssec[k] = 0;
    end
  endtask

  // One clock edge of the alarm rules, with the inputs seen at that edge.
  task automatic m_step(input int k, input bit a, input bit t, input bit s, input bit d, input bit match);
    bit trig;
    int nv;
    trig = match && !m_prev[k];
    m_prev[k] = match;
    if (!a) begin
      m_act[k] = 0; m_ring[k] = 0; m_snz[k] = 0; m_vol[k] = 0;
    end else if (!m_act[k]) begin
      m_act[k] = 1;
    end else if (m_ring[k]) begin
      if (d) begin
        m_ring[k] = 0; m_vol[k] = 0;
      end else if (s && m_left[k] > 0) begin
        m_ring[k] = 0; m_snz[k] = 1; m_vol[k] = 0;
        m_left[k] = m_left[k] - 1; m_ssec[k] = SNZ;
      end else if (t) begin
        m_rsec[k] = m_rsec[k] + 1;
        if (m_rsec[k] >= RING) begin
          m_ring[k] = 0; m_vol[k] = 0;
        end else begin
          nv = m_vol[k] + step_of(k);
          m_vol[k] = (nv > MAXV) ? MAXV : nv;
        end
      end
    end else if (m_snz[k]) begin
      if (d) begin
        m_snz[k] = 0;
      end else if (t) begin
        m_ssec[k] = m_ssec[k] - 1;
        if (m_ssec[k] == 0) begin
          m_snz[k] = 0; m_ring[k] = 1; m_vol[k] = step_of(k); m_rsec[k] = 0;
        end
      end
    end else if (trig) begin
      m_ring[k] = 1; m_left[k] = SMAX; m_vol[k] = step_of(k); m_rsec[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("vol%0d", k), vol[k], m_vol[k]);
      check($sformatf("ringing%0d", k), ringing[k], m_ring[k]);
      check($sformatf("snoozing%0d", k), snoozing[k], m_snz[k]);
      check($sformatf("indicator%0d", k), ind[k], m_act[k]);
      check($sformatf("snooze_left%0d", k), sl[k], m_left[k]);
    end
  endtask

  task automatic cycle(input bit t, input logic [23:0] tnow, input bit a, input bit s, input bit d);
    @(negedge CLK);
    tick = t; tn = tnow; arm = a; snz = s; dis = d;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) m_step(k, a, t, s, d, tnow == at);
    check_all();
    tick = 1'b0; snz = 1'b0; dis = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    #2;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async_vol%0d", k), vol[k], 0);
      check($sformatf("async_ring%0d", k), ringing[k], 0);
      check($sformatf("async_ind%0d", k), ind[k], 0);
    end
    m_reset();
    @(posedge CLK);
    #1;
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] tr;
    reset = 1'b0; tick = 1'b0; tn = 24'h0; at = T_ALARM;
    arm = 1'b0; snz = 1'b0; dis = 1'b0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    reset = 1'b1;

    // Trigger and ramp, saturation on instance b, timeout, no retrigger.
    cycle(0, T_PRE, 1, 0, 0);
    check("armed_ind", ind[0], 1);
    cycle(0, T_ALARM, 1, 0, 0);
    check("trig_ring", ringing[0], 1);
    check("trig_vol_a", vol[0], 'h20);
    check("trig_vol_b", vol[1], 'h50);
    check("trig_left", sl[0], 2);
    cycle(1, T_ALARM, 1, 0, 0);
    check("ramp1_a", vol[0], 'h40);
    check("ramp1_b", vol[1], 'hA0);
    cycle(0, T_ALARM, 1, 0, 0);
    cycle(1, T_ALARM, 1, 0, 0);
    check("ramp2_a", vol[0], 'h60);
    check("ramp2_b", vol[1], 'hE0);
    cycle(1, T_ALARM, 1, 0, 0);
    check("ramp3_b", vol[1], 'hE0);
    cycle(1, T_ALARM, 1, 0, 0);
    check("ramp4_a", vol[0], 'hA0);
    cycle(1, T_ALARM, 1, 0, 0);
    check("timeout_ring", ringing[0], 0);
    check("timeout_vol", vol[0], 0);
    check("timeout_ind", ind[0], 1);
    repeat (4) cycle(0, T_ALARM, 1, 0, 0);
    check("no_retrigger", ringing[0], 0);

    // Snooze twice, third snooze ignored, then dismiss+snooze conflict.
    cycle(0, T_PRE, 1, 0, 0);
    cycle(0, T_ALARM, 1, 0, 0);
    cycle(0, T_ALARM, 1, 1, 0);
    check("snz1_state", snoozing[0], 1);
    check("snz1_left", sl[0], 1);
    check("snz1_vol", vol[0], 0);
    repeat (2) cycle(1, T_ALARM, 1, 0, 0);
    check("snz1_hold", snoozing[0], 1);
    cycle(1, T_ALARM, 1, 0, 0);
    check("snz1_wake", ringing[0], 1);
    check("snz1_wake_vol", vol[0], 'h20);
    cycle(0, T_ALARM, 1, 1, 0);
    check("snz2_left", sl[0], 0);
    repeat (3) cycle(1, T_ALARM, 1, 0, 0);
    cycle(0, T_ALARM, 1, 1, 0);
    check("snz3_ignored", ringing[0], 1);
    check("snz3_no_snooze", snoozing[0], 0);
    cycle(0, T_ALARM, 1, 1, 1);
    check("conflict_ring", ringing[0], 0);
    check("conflict_snz", snoozing[0], 0);
    check("conflict_left", sl[0], 0);
    cycle(0, T_PRE, 1, 0, 0);
    cycle(0, T_ALARM, 1, 0, 0);
    check("reload_left", sl[0], 2);
    cycle(0, T_ALARM, 0, 0, 1);
    check("disarm_ind", ind[0], 0);
    check("disarm_vol", vol[0], 0);

    // Asynchronous reset while ringing.
    cycle(0, T_PRE, 1, 0, 0);
    cycle(0, T_PRE, 1, 0, 0);
    cycle(0, T_ALARM, 1, 0, 0);
    cycle(1, T_ALARM, 1, 0, 0);
    check("pre_reset_vol", vol[0], 'h40);
    reset_pulse();

    // Randomized traffic.
    tr = T_ALARM;
    for (int i = 0; i < 4000; i++) begin
      bit t;
      t = ($urandom_range(0, 3) == 0);
      if (t) begin
        case ($urandom_range(0, 3))
          0: tr = T_PRE;
          3: tr = T_POST;
          default: tr = T_ALARM;
        endcase
      end
      cycle(t, tr, $urandom_range(0, 79) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) reset_pulse();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
